// File: rtl/pc_ret_stack.sv
// Program-counter stage with a hardware return-address stack.
// Selects next PC from return / call / relative / absolute / increment
// requests and keeps sticky overflow/underflow flags for bad call/return.
module pc_ret_stack #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             s_inc,
  input  logic             s_rel,
  input  logic             s_ret,
  input  logic             enablebackup,
  input  logic [PC_W-1:0]  target,
  input  logic [PC_W-1:0]  offset,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0]  stack [DEPTH];
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_nxt;
  logic [PC_W-1:0]  pop_data;
  logic [CNT_W-1:0] count_nxt;
  logic             overflow_nxt;
  logic             underflow_nxt;
  logic             push;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;

  assign pc_inc   = pc + PC_W'(1);
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  // Pop index wraps to DEPTH-1 when count==DEPTH, whose low bits are zero.
  assign push_idx = count[AW-1:0];
  assign pop_idx  = push_idx - AW'(1);
  assign pop_data = stack[pop_idx];

  // Next-state selection: return, call, relative, absolute, increment.
  always_comb begin
    pc_nxt        = pc_inc;
    count_nxt     = count;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    push          = 1'b0;
    if (stall) begin
      pc_nxt = pc;
    end else if (s_ret) begin
      if (!empty) begin
        pc_nxt    = pop_data;
        count_nxt = count - CNT_W'(1);
      end else begin
        underflow_nxt = 1'b1;
      end
    end else if (enablebackup) begin
      if (!full) begin
        push      = 1'b1;
        pc_nxt    = target;
        count_nxt = count + CNT_W'(1);
      end else begin
        overflow_nxt = 1'b1;
      end
    end else if (s_rel) begin
      pc_nxt = pc + offset;
    end else if (!s_inc) begin
      pc_nxt = target;
    end
  end

  // PC, occupancy and sticky flags; reset overrides stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      count     <= count_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  // Return-address storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack[push_idx] <= pc_inc;
    end
  end

endmodule
